// File: rtl/run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and end-reason codes.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [1:0] REASON_NONE   = 2'd0;
  localparam logic [1:0] REASON_BUDGET = 2'd1;
  localparam logic [1:0] REASON_HALT   = 2'd2;

  // Run-cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/run_halt_detect.sv
// Halt detector: flags a CPU halt once the PC has stayed unchanged for HALT_STABLE RUN cycles.
// Latency: halt_o is combinational in the RUN cycle that reaches the count.
// Backpressure: none; only advances while run_i is high.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        restart pulse; forgets the previous PC and the stable count
//   run_i          high in RUN cycles; the only cycles that are tracked
//   pc_i           CPU program counter
//   halt_o         halt pulse; constant 0 when HALT_STABLE == 0
module run_halt_detect
  import run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HALT_STABLE = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            run_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            halt_o
);

  if (HALT_STABLE == 0) begin : g_off
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, clear_i, run_i, pc_i};
    assign halt_o    = 1'b0;
  end else begin : g_on
    localparam int            SW     = $clog2(HALT_STABLE + 1);
    localparam logic [SW-1:0] TARGET = SW'(HALT_STABLE);

    logic [PC_W-1:0] prev_pc_q;
    logic            seen_q;     // prev_pc_q holds a real sample from this run
    logic [SW-1:0]   stable_q;
    logic [SW-1:0]   stable_d;

    // The first RUN cycle has no valid previous PC, so it can never count as stable.
    always_comb begin
      stable_d = '0;
      if (seen_q && (pc_i == prev_pc_q)) begin
        stable_d = (stable_q == TARGET) ? stable_q : stable_q + SW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
        prev_pc_q <= '0;
        seen_q    <= 1'b0;
        stable_q  <= '0;
      end else if (run_i) begin
        prev_pc_q <= pc_i;
        seen_q    <= 1'b1;
        stable_q  <= stable_d;
      end
    end

    assign halt_o = run_i && (stable_d == TARGET);
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the CPU in reset, runs it until budget or halt, then dumps the register file.
// Latency: RST_CYCLES hold, up to END_COUNT run cycles, then one beat per two cycles at best.
// Backpressure: dump beat held stable while dump_valid_o=1 and dump_ready_i=0.
//
// Optional feature macro: RUN_CTRL_CHECKSUM_EN appends one beat (idx NUM_REGS) carrying the XOR
// of all dumped register values.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               start pulse, honoured in IDLE and DONE only
//   cpu_rst_o             CPU reset (0 = CPU held in reset)
//   cpu_clk_en_o          CPU clock enable (HOLD and RUN)
//   pc_i                  CPU program counter for halt detection
//   rf_addr_o/rf_data_i   register-file read port (combinational read)
//   dump_valid_o/_ready_i valid/ready handshake for dump beats
//   dump_idx_o/_data_o    beat index and data
//   done_o                dump complete, held until restart
//   end_reason_o          0 none, 1 budget, 2 halt
//   cycle_cnt_o           run cycles elapsed, frozen after RUN
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 5,
  parameter int          NUM_REGS    = 12,
  parameter logic [31:0] END_COUNT   = 32'd5,
  parameter int          RST_CYCLES  = 1,
  parameter int          PC_W        = 32,
  parameter int          HALT_STABLE = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              cpu_rst_o,
  output logic              cpu_clk_en_o,
  input  logic [PC_W-1:0]   pc_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W:0]   dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o,
  output logic [1:0]        end_reason_o,
  output logic [31:0]       cycle_cnt_o
);

`ifdef RUN_CTRL_CHECKSUM_EN
  localparam int LAST_INT = NUM_REGS;
`else
  localparam int LAST_INT = NUM_REGS - 1;
`endif
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(LAST_INT);
  localparam int              HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_CYCLES - 1);

  state_e              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [1:0]          reason_q, reason_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     didx_q, didx_d;
  logic [DATA_W-1:0]   data_q, data_d;
`ifdef RUN_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  logic restart;
  logic run;
  logic halt_pulse;

  assign restart = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign run     = (state_q == ST_RUN);

  run_halt_detect #(
    .PC_W       (PC_W),
    .HALT_STABLE(HALT_STABLE)
  ) u_halt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(restart),
    .run_i  (run),
    .pc_i   (pc_i),
    .halt_o (halt_pulse)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    reason_d = reason_q;
    idx_d    = idx_q;
    didx_d   = didx_q;
    data_d   = data_q;
`ifdef RUN_CTRL_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d  = ST_HOLD;
          hold_d   = '0;
          cnt_d    = '0;
          reason_d = REASON_NONE;
          idx_d    = '0;
`ifdef RUN_CTRL_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                     hold_d  = hold_q + HW'(1);
      end
      ST_RUN: begin
        cnt_d = sat_inc32(cnt_q);
        // Halt wins when both stop conditions land in the same cycle.
        if (halt_pulse) begin
          reason_d = REASON_HALT;
          state_d  = ST_LOAD;
        end else if (cnt_d == END_COUNT) begin
          reason_d = REASON_BUDGET;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        didx_d  = idx_q;
        data_d  = rf_data_i;
`ifdef RUN_CTRL_CHECKSUM_EN
        if (idx_q == LAST_IDX) data_d = csum_q;
        else                   csum_d = csum_q ^ rf_data_i;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (dump_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + (ADDR_W + 1)'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      cnt_q    <= '0;
      reason_q <= REASON_NONE;
      idx_q    <= '0;
      didx_q   <= '0;
      data_q   <= '0;
`ifdef RUN_CTRL_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      reason_q <= reason_d;
      idx_q    <= idx_d;
      didx_q   <= didx_d;
      data_q   <= data_d;
`ifdef RUN_CTRL_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // The CPU leaves reset at RUN and stays out of it (clock gated) so its state is frozen for the dump.
  assign cpu_rst_o    = !((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign cpu_clk_en_o = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign rf_addr_o    = idx_q[ADDR_W-1:0];
  assign dump_valid_o = (state_q == ST_SEND);
  assign dump_idx_o   = didx_q;
  assign dump_data_o  = data_q;
  assign done_o       = (state_q == ST_DONE);
  assign end_reason_o = reason_q;
  assign cycle_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 12;
`ifdef RUN_CTRL_CHECKSUM_EN
  localparam int NBEATS = NUM_REGS + 1;
`else
  localparam int NBEATS = NUM_REGS;
`endif

  typedef struct packed {
    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: default parameters (budget stop, dump)
  logic start_a, ready_a, cpu_rst_a, clk_en_a, valid_a, done_a;
  logic [31:0] pc_a, cnt_a, data_a, rf_data_a;
  logic [ADDR_W-1:0] rf_addr_a;
  logic [ADDR_W:0] idx_a;
  logic [1:0] reason_a;
  assign rf_data_a = 32'(rf_addr_a) * 32'd3;

  // Instance B: halt stop
  logic start_b, ready_b, cpu_rst_b, clk_en_b, valid_b, done_b;
  logic [31:0] pc_b, cnt_b, data_b, rf_data_b;
  logic [ADDR_W-1:0] rf_addr_b;
  logic [ADDR_W:0] idx_b;
  logic [1:0] reason_b;
  assign rf_data_b = 32'(rf_addr_b);

  // Instance C: budget and halt in the same cycle
  logic start_c, ready_c, cpu_rst_c, clk_en_c, valid_c, done_c;
  logic [31:0] pc_c, cnt_c, data_c, rf_data_c;
  logic [ADDR_W-1:0] rf_addr_c;
  logic [ADDR_W:0] idx_c;
  logic [1:0] reason_c;
  assign rf_data_c = 32'(rf_addr_c);

  cpu_run_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .cpu_rst_o(cpu_rst_a), .cpu_clk_en_o(clk_en_a),
    .pc_i(pc_a), .rf_addr_o(rf_addr_a), .rf_data_i(rf_data_a), .dump_valid_o(valid_a),
    .dump_ready_i(ready_a), .dump_idx_o(idx_a), .dump_data_o(data_a), .done_o(done_a),
    .end_reason_o(reason_a), .cycle_cnt_o(cnt_a)
  );

  cpu_run_ctrl #(.END_COUNT(32'd100), .HALT_STABLE(4)) u_halt (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .cpu_rst_o(cpu_rst_b), .cpu_clk_en_o(clk_en_b),
    .pc_i(pc_b), .rf_addr_o(rf_addr_b), .rf_data_i(rf_data_b), .dump_valid_o(valid_b),
    .dump_ready_i(ready_b), .dump_idx_o(idx_b), .dump_data_o(data_b), .done_o(done_b),
    .end_reason_o(reason_b), .cycle_cnt_o(cnt_b)
  );

  cpu_run_ctrl #(.END_COUNT(32'd6), .HALT_STABLE(5)) u_both (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .cpu_rst_o(cpu_rst_c), .cpu_clk_en_o(clk_en_c),
    .pc_i(pc_c), .rf_addr_o(rf_addr_c), .rf_data_i(rf_data_c), .dump_valid_o(valid_c),
    .dump_ready_i(ready_c), .dump_idx_o(idx_c), .dump_data_o(data_c), .done_o(done_c),
    .end_reason_o(reason_c), .cycle_cnt_o(cnt_c)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    pc_a = '0; pc_b = '0; pc_c = 32'd100;
    tick(); tick();
    total++;
    if ({cpu_rst_a, clk_en_a, valid_a, done_a} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {cpu_rst_a, clk_en_a, valid_a, done_a});
    end
    total++;
    if ({reason_a, cnt_a} !== 34'd0) begin
      bad++; $display("FAIL reset_status reason=%0d cnt=%0d want 0/0", reason_a, cnt_a);
    end
    total++;
    if ({rf_addr_a, idx_a, data_a} !== '0) begin
      bad++; $display("FAIL reset_dump addr=%0d idx=%0d data=%0h want 0", rf_addr_a, idx_a, data_a);
    end
    rst = 1'b0;
  endtask

  // Start A and run it to the end of RUN; leaves A in LOAD.
  task automatic test_budget();
    int hold = 0;
    int run  = 0;
    bit fin  = 0;
    tick(); tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    total++;
    if ({done_a, reason_a, cnt_a} !== 35'd0) begin
      bad++; $display("FAIL start_clear done=%b reason=%0d cnt=%0d want 0", done_a, reason_a, cnt_a);
    end
    for (int i = 0; i < 40 && !fin; i++) begin
      if (!cpu_rst_a && clk_en_a) begin
        hold++;
        start_a = 1'b0;
      end else if (cpu_rst_a && clk_en_a) begin
        total++;
        if (cnt_a !== 32'(run)) begin
          bad++; $display("FAIL run_cnt got=%0d want=%0d", cnt_a, run);
        end
        start_a = (run == 2);  // start during RUN must be ignored
        run++;
      end else if (cpu_rst_a && !clk_en_a) begin
        fin = 1;
        start_a = 1'b0;
      end
      if (!fin) begin
        pc_a = pc_a + 32'd4;
        tick();
      end
    end
    total++;
    if (!fin) begin
      bad++; $display("FAIL budget_timeout run did not end");
    end
    total++;
    if (hold !== 1) begin
      bad++; $display("FAIL hold_cycles got=%0d want=1", hold);
    end
    total++;
    if (run !== 5) begin
      bad++; $display("FAIL run_cycles got=%0d want=5", run);
    end
    total++;
    if ({reason_a, cnt_a} !== {2'd1, 32'd5}) begin
      bad++; $display("FAIL budget_result reason=%0d cnt=%0d want 1/5", reason_a, cnt_a);
    end
  endtask

  // Dump A with a 3-cycle stall on beat 2; scoreboard checks every accepted beat.
  task automatic test_dump_backpressure();
    logic [31:0] csum = '0;
    beat_t e;
    int beats = 0;
    int stall = 0;
    bit fin = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      e.idx  = (ADDR_W + 1)'(i);
      e.data = 32'(i * 3);
      csum   = csum ^ e.data;
      exp_q.push_back(e);
    end
`ifdef RUN_CTRL_CHECKSUM_EN
    e.idx  = (ADDR_W + 1)'(NUM_REGS);
    e.data = csum;
    exp_q.push_back(e);
`endif
    for (int i = 0; i < 300 && !fin; i++) begin
      if (done_a) begin
        fin = 1;
      end else if (valid_a) begin
        if (idx_a == 2 && stall < 3) begin
          ready_a = 1'b0;
          stall++;
          total++;
          if ({idx_a, data_a} !== {6'd2, 32'd6}) begin
            bad++; $display("FAIL stall_hold idx=%0d data=%0d want 2/6", idx_a, data_a);
          end
        end else begin
          ready_a = 1'b1;
          beats++;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL extra_beat idx=%0d data=%0d want none", idx_a, data_a);
          end else begin
            e = exp_q.pop_front();
            if ({idx_a, data_a} !== {e.idx, e.data}) begin
              bad++; $display("FAIL beat idx=%0d data=%0d want %0d/%0d", idx_a, data_a, e.idx, e.data);
            end
          end
        end
      end else begin
        ready_a = 1'b1;  // ready ahead of valid must not complete a beat
      end
      if (!fin) tick();
    end
    total++;
    if (!fin) begin
      bad++; $display("FAIL dump_timeout done never rose");
    end
    total++;
    if (beats !== NBEATS || exp_q.size() != 0) begin
      bad++; $display("FAIL beat_count got=%0d want=%0d left=%0d", beats, NBEATS, exp_q.size());
    end
    total++;
    if ({valid_a, done_a, cpu_rst_a, clk_en_a} !== 4'b0110) begin
      bad++; $display("FAIL done_state got=%b want=0110", {valid_a, done_a, cpu_rst_a, clk_en_a});
    end
    exp_q.delete();
    ready_a = 1'b1;
  endtask

  task automatic test_halt();
    int run = 0;
    bit fin = 0;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 60 && !fin; i++) begin
      if (cpu_rst_b && clk_en_b) begin
        pc_b = (run < 2) ? 32'(run * 4) : 32'd8;  // 0,4,8,8,8,...
        run++;
      end else if (cpu_rst_b && !clk_en_b) begin
        fin = 1;
      end
      if (!fin) tick();
    end
    total++;
    if (!fin) begin
      bad++; $display("FAIL halt_timeout");
    end
    total++;
    if (run !== 7) begin
      bad++; $display("FAIL halt_run_cycles got=%0d want=7", run);
    end
    total++;
    if ({reason_b, cnt_b} !== {2'd2, 32'd7}) begin
      bad++; $display("FAIL halt_result reason=%0d cnt=%0d want 2/7", reason_b, cnt_b);
    end
  endtask

  task automatic test_simultaneous();
    int run = 0;
    bit fin = 0;
    tick();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 0; i < 60 && !fin; i++) begin
      if (cpu_rst_c && clk_en_c) run++;
      else if (cpu_rst_c && !clk_en_c) fin = 1;
      if (!fin) tick();
    end
    total++;
    if (!fin) begin
      bad++; $display("FAIL both_timeout");
    end
    total++;
    if (run !== 6) begin
      bad++; $display("FAIL both_run_cycles got=%0d want=6", run);
    end
    total++;
    if ({reason_c, cnt_c} !== {2'd2, 32'd6}) begin
      bad++; $display("FAIL both_result reason=%0d cnt=%0d want 2/6", reason_c, cnt_c);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (valid_a && idx_a == 4) found = 1;
      else begin
        ready_a = 1'b1;
        pc_a = pc_a + 32'd4;
        tick();
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL mid_dump_timeout beat 4 never seen");
    end
    rst = 1'b1;
    ready_a = 1'b0;
    tick();
    total++;
    if ({cpu_rst_a, clk_en_a, valid_a, done_a} !== 4'b0) begin
      bad++; $display("FAIL mid_reset_ctrl got=%b want=0000", {cpu_rst_a, clk_en_a, valid_a, done_a});
    end
    total++;
    if ({reason_a, cnt_a, rf_addr_a, idx_a, data_a} !== '0) begin
      bad++; $display("FAIL mid_reset_regs reason=%0d cnt=%0d idx=%0d data=%0h want 0",
                      reason_a, cnt_a, idx_a, data_a);
    end
    rst = 1'b0;
    ready_a = 1'b1;
    test_budget();
    test_dump_backpressure();
  endtask

  initial begin
    test_reset();
    test_budget();
    test_dump_backpressure();
    test_halt();
    test_simultaneous();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
